// File: rtl/fetch_sequencer.sv
// ============================================================================
// fetch_sequencer : owns the PC, drives req/ack instruction fetches, buffers
//                   returned words in a 2-entry FIFO for decode.
// Revision        : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned PC_STEP  = 4,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        busy,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    ERR   = 2'd3
  } state_t;

  localparam logic [31:0] STEP       = 32'(PC_STEP);
  localparam logic [7:0]  WAIT_LIMIT = 8'(MAX_WAIT - 1);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] fifo_pc    [2];
  logic [31:0] fifo_instr [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic [7:0]  wait_cnt;

  logic        pop;
  logic        push;
  logic        timeout;
  logic [1:0]  count_next;
  logic [31:0] pc_inc;

  assign pop        = (count != 2'd0) && out_ready;
  assign push       = imem_req && imem_ack && (state == FETCH) && !redirect;
  assign count_next = count + {1'b0, push} - {1'b0, pop};
  // Fires on the MAX_WAIT-th consecutive cycle of an unanswered request.
  assign timeout    = imem_req && !imem_ack && (wait_cnt >= WAIT_LIMIT);
  assign pc_inc     = pc + STEP;

  assign out_valid  = (count != 2'd0);
  assign out_pc     = fifo_pc[rd_ptr];
  assign out_instr  = fifo_instr[rd_ptr];
  assign busy       = imem_req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      imem_req      <= 1'b0;
      imem_addr     <= RESET_PC;
      fetch_err     <= 1'b0;
      wait_cnt      <= 8'd0;
      count         <= 2'd0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      fifo_pc[0]    <= 32'd0;
      fifo_pc[1]    <= 32'd0;
      fifo_instr[0] <= 32'd0;
      fifo_instr[1] <= 32'd0;
    end else begin
      if (!imem_req || imem_ack) begin
        wait_cnt <= 8'd0;
      end else if (wait_cnt != 8'hFF) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      if (redirect) begin
        count  <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push) begin
          fifo_pc[wr_ptr]    <= imem_addr;
          fifo_instr[wr_ptr] <= imem_data;
          wr_ptr             <= ~wr_ptr;
        end
        if (pop) begin
          rd_ptr <= ~rd_ptr;
        end
        count <= count_next;
      end

      if (redirect) begin
        pc        <= redirect_pc & ~32'h3;
        fetch_err <= 1'b0;
        // An unanswered request must still complete before refetching.
        if (imem_req && !imem_ack) begin
          state <= DRAIN;
        end else begin
          state    <= FETCH;
          imem_req <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (run) begin
              state     <= FETCH;
              imem_req  <= 1'b1;
              imem_addr <= pc;
            end
          end
          FETCH: begin
            if (imem_req) begin
              if (imem_ack) begin
                pc <= pc_inc;
                // Back-to-back only if the FIFO will still have room after this push.
                if (run && (count_next < 2'd2)) begin
                  imem_addr <= pc_inc;
                end else begin
                  imem_req <= 1'b0;
                end
              end else if (timeout) begin
                state     <= ERR;
                imem_req  <= 1'b0;
                fetch_err <= 1'b1;
              end
            end else if (run && (count < 2'd2)) begin
              imem_req  <= 1'b1;
              imem_addr <= pc;
            end
          end
          DRAIN: begin
            if (imem_ack) begin
              state    <= FETCH;
              imem_req <= 1'b0;
            end else if (timeout) begin
              state     <= ERR;
              imem_req  <= 1'b0;
              fetch_err <= 1'b1;
            end
          end
          ERR: begin
            imem_req <= 1'b0;
          end
          default: begin
            state    <= IDLE;
            imem_req <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// tb_fetch_sequencer : self-checking bench for fetch_sequencer.
// Revision           : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = 32'd0;
  logic        out_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        busy;
  logic        fetch_err;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_sequencer #(
    .RESET_PC (32'h0),
    .PC_STEP  (4),
    .MAX_WAIT (15)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .busy        (busy),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  // Memory contents: a bijective function of the address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'hC3A5};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Instruction memory model: fixed or random wait states, or never answers.
  bit          mem_on    = 1'b1;
  bit          mem_rand  = 1'b0;
  int          mem_wait  = 0;
  int          wait_left = 0;
  bit          in_txn    = 1'b0;
  logic [31:0] txn_addr  = 32'd0;

  always @(negedge clk) begin
    if (!reset) begin
      in_txn   = 1'b0;
      imem_ack = 1'b0;
    end else begin
      if (imem_ack) in_txn = 1'b0;
      if (imem_req && mem_on) begin
        if (!in_txn) begin
          in_txn    = 1'b1;
          txn_addr  = imem_addr;
          wait_left = mem_rand ? int'($urandom_range(3, 0)) : mem_wait;
        end else begin
          chk("addr_stable", imem_addr, txn_addr);
        end
        if (wait_left == 0) begin
          imem_ack  = 1'b1;
          imem_data = memf(imem_addr);
        end else begin
          imem_ack = 1'b0;
          wait_left--;
        end
      end else begin
        imem_ack = 1'b0;
        in_txn   = 1'b0;
      end
    end
  end

  // Row k: outputs expected at the k-th falling edge after reset release,
  // and the inputs driven there for the following rising edge.
  typedef struct {
    logic        run;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] epc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic y, input logic d, input logic [31:0] rp,
                              input logic q, input logic [31:0] a, input logic v, input logic [31:0] p);
    vec_t t;
    t.run = r; t.rdy = y; t.redir = d; t.rpc = rp;
    t.ereq = q; t.eaddr = a; t.evalid = v; t.epc = p;
    return t;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b0;
    run       = 1'b0;
    out_ready = 1'b0;
    redirect  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_table(input int first, input int last, input int wt, input string tag);
    mem_on   = 1'b1;
    mem_rand = 1'b0;
    mem_wait = wt;
    do_reset();
    for (int i = first; i <= last; i++) begin
      if (i != first) @(negedge clk);
      chk($sformatf("%s[%0d].req", tag, i - first), imem_req, tbl[i].ereq);
      chk($sformatf("%s[%0d].busy", tag, i - first), busy, tbl[i].ereq);
      chk($sformatf("%s[%0d].addr", tag, i - first), imem_addr, tbl[i].eaddr);
      chk($sformatf("%s[%0d].valid", tag, i - first), out_valid, tbl[i].evalid);
      if (tbl[i].evalid) begin
        chk($sformatf("%s[%0d].pc", tag, i - first), out_pc, tbl[i].epc);
        chk($sformatf("%s[%0d].instr", tag, i - first), out_instr, memf(tbl[i].epc));
      end
      run         = tbl[i].run;
      out_ready   = tbl[i].rdy;
      redirect    = tbl[i].redir;
      redirect_pc = tbl[i].rpc;
    end
    redirect = 1'b0;
  endtask

  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int          nreq;
    int          pops;
    logic [31:0] exp_pc;

    // Zero-wait streaming, backpressure to a full FIFO, then run=0 (rows 0..12)
    tbl.push_back(mk(1, 1, 0, 0, 0, 32'd0,  0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 32'd0,  0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 32'd4,  1, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 32'd8,  1, 4));
    tbl.push_back(mk(1, 1, 0, 0, 1, 32'd12, 1, 8));
    tbl.push_back(mk(1, 0, 0, 0, 1, 32'd16, 1, 12));
    tbl.push_back(mk(1, 0, 0, 0, 0, 32'd16, 1, 12));
    tbl.push_back(mk(1, 1, 0, 0, 0, 32'd16, 1, 12));
    tbl.push_back(mk(1, 1, 0, 0, 0, 32'd16, 1, 16));
    tbl.push_back(mk(1, 1, 0, 0, 1, 32'd20, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 32'd24, 1, 20));
    tbl.push_back(mk(0, 1, 0, 0, 0, 32'd24, 1, 24));
    tbl.push_back(mk(0, 1, 0, 0, 0, 32'd24, 0, 0));
    // Three wait states (rows 13..22)
    tbl.push_back(mk(1, 1, 0, 0, 0, 32'd0, 0, 0));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(1, 1, 0, 0, 1, 32'd0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 32'd4, 1, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(1, 1, 0, 0, 1, 32'd4, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 32'd8, 1, 4));
    // Redirect to 0x103 during an outstanding 3-wait request (rows 23..33)
    tbl.push_back(mk(1, 1, 0, 0,        0, 32'd0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 32'h103,  1, 32'd0, 0, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(1, 1, 0, 0, 1, 32'd0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 32'd0, 0, 0));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(1, 1, 0, 0, 1, 32'h100, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 32'h104, 1, 32'h100));

    run_table(0, 12, 0, "stream");
    run_table(13, 22, 3, "wait3");
    run_table(23, 33, 3, "redir");

    // Hung memory: timeout into ERR, then recovery through redirect
    mem_on = 1'b0;
    do_reset();
    run       = 1'b1;
    out_ready = 1'b1;
    nreq      = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (imem_req) nreq++;
      else break;
    end
    chk("timeout.req_cycles", nreq, 15);
    chk("timeout.err", fetch_err, 1);
    chk("timeout.req", imem_req, 0);
    repeat (3) @(negedge clk);
    chk("timeout.err_sticky", fetch_err, 1);
    chk("timeout.busy", busy, 0);
    mem_on      = 1'b1;
    mem_wait    = 0;
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    @(negedge clk);
    redirect = 1'b0;
    chk("timeout.err_clear", fetch_err, 0);
    chk("timeout.req_idle", imem_req, 0);
    @(negedge clk);
    chk("timeout.req_new", imem_req, 1);
    chk("timeout.addr_new", imem_addr, 32'h40);
    @(negedge clk);
    chk("timeout.valid", out_valid, 1);
    chk("timeout.pc", out_pc, 32'h40);
    chk("timeout.instr", out_instr, memf(32'h40));

    // Asynchronous reset in the middle of a request
    mem_wait = 1;
    do_reset();
    run       = 1'b1;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("areset.pre_valid", out_valid, 1);
    chk("areset.pre_req", imem_req, 1);
    #2 reset = 1'b0;
    #1;
    chk("areset.req", imem_req, 0);
    chk("areset.valid", out_valid, 0);
    chk("areset.busy", busy, 0);
    chk("areset.pc", out_pc, 0);
    chk("areset.instr", out_instr, 0);
    chk("areset.err", fetch_err, 0);
    @(negedge clk);
    reset     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("areset.refetch_req", imem_req, 1);
    chk("areset.refetch_addr", imem_addr, 32'h0);
    repeat (2) @(negedge clk);
    chk("areset.refetch_valid", out_valid, 1);
    chk("areset.refetch_pc", out_pc, 32'h0);

    // Random traffic against an in-order stream model
    mem_rand = 1'b1;
    mem_on   = 1'b1;
    do_reset();
    exp_pc = 32'h0;
    pops   = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c != 0) @(negedge clk);
      run         = ($urandom_range(7, 0) != 0);
      out_ready   = ($urandom_range(3, 0) != 0);
      redirect    = ($urandom_range(31, 0) == 0);
      redirect_pc = $urandom();
      if (redirect) begin
        exp_pc = redirect_pc & ~32'h3;
      end else if (out_valid && out_ready) begin
        chk("random.pc", out_pc, exp_pc);
        chk("random.instr", out_instr, memf(exp_pc));
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
    end
    @(negedge clk);
    redirect = 1'b0;
    chk("random.err", fetch_err, 0);
    chk("random.enough_pops", 32'(pops >= 200), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
